// File: rtl/serv_bufreg_seq.sv
// Buffer-register sequencer: init strobes, alignment check,
// then a data-bus cycle or a serial shift phase.
module serv_bufreg_seq #(
  parameter int ALIGN_CHK = 1,
  parameter int SHIFT_EN  = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [1:0] i_op,
  input  logic [1:0] i_size,
  input  logic [4:0] i_shamt,
  input  logic [1:0] i_lsb,
  input  logic       i_dbus_ack,
  output logic       o_busy,
  output logic       o_en,
  output logic       o_init,
  output logic       o_cnt0,
  output logic       o_cnt1,
  output logic       o_dbus_cyc,
  output logic       o_done,
  output logic       o_misalign,
  output logic [4:0] o_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_CHECK,
    S_BUS,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [1:0] op_q, op_d;
  logic [1:0] size_q, size_d;
  logic [4:0] shamt_q, shamt_d;
  logic       mis_q, mis_d;
  logic       misal;

  assign misal = ((size_q == 2'b01) & i_lsb[0])
               | (size_q[1] & (|i_lsb));

  // State, counter and latched operation registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      op_q    <= 2'b00;
      size_q  <= 2'b00;
      shamt_q <= 5'd0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      size_q  <= size_d;
      shamt_q <= shamt_d;
      mis_q   <= mis_d;
    end
  end

  // Next-state and counter sequencing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    size_d  = size_q;
    shamt_d = shamt_q;
    mis_d   = mis_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_INIT;
          cnt_d   = 5'd0;
          op_d    = i_op;
          size_d  = i_size;
          shamt_d = i_shamt;
          mis_d   = 1'b0;
        end
      end
      S_INIT: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        cnt_d = 5'd0;
        if (!op_q[1]) begin
          if ((ALIGN_CHK != 0) && misal) begin
            state_d = S_DONE;
            mis_d   = 1'b1;
          end else begin
            state_d = S_BUS;
          end
        end else if ((op_q == 2'b10) && (SHIFT_EN != 0)
                     && (shamt_q != 5'd0)) begin
          state_d = S_SHIFT;
        end else begin
          state_d = S_DONE;
        end
      end
      S_BUS: begin
        if (i_dbus_ack) begin
          state_d = S_DONE;
        end
      end
      S_SHIFT: begin
        if (cnt_q == shamt_q - 5'd1) begin
          state_d = S_DONE;
          cnt_d   = 5'd0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 5'd0;
      end
    endcase
  end

  // Strobes decoded from the current state
  always_comb begin
    o_busy     = 1'b1;
    o_en       = 1'b0;
    o_init     = 1'b0;
    o_cnt0     = 1'b0;
    o_cnt1     = 1'b0;
    o_dbus_cyc = 1'b0;
    o_done     = 1'b0;
    o_misalign = 1'b0;
    o_cnt      = cnt_q;
    unique case (state_q)
      S_IDLE: o_busy = 1'b0;
      S_INIT: begin
        o_en   = 1'b1;
        o_init = 1'b1;
        o_cnt0 = (cnt_q == 5'd0);
        o_cnt1 = (cnt_q == 5'd1);
      end
      S_CHECK: o_busy = 1'b1;
      S_BUS:   o_dbus_cyc = 1'b1;
      S_SHIFT: o_en = 1'b1;
      S_DONE: begin
        o_done     = 1'b1;
        o_misalign = mis_q;
      end
      default: o_busy = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_serv_bufreg_seq.sv
// Bench for serv_bufreg_seq: timeline model of two instances
// (default, and alignment/shift disabled) plus directed pins.
module tb_serv_bufreg_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_start;
  logic [1:0] i_op;
  logic [1:0] i_size;
  logic [4:0] i_shamt;
  logic [1:0] i_lsb;
  logic       i_dbus_ack;

  logic [1:0] busy, en, init, cnt0, cnt1, dbus, done, misal;
  logic [4:0] cnt [2];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serv_bufreg_seq #(.ALIGN_CHK(1), .SHIFT_EN(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start),
    .i_op(i_op), .i_size(i_size), .i_shamt(i_shamt),
    .i_lsb(i_lsb), .i_dbus_ack(i_dbus_ack),
    .o_busy(busy[0]), .o_en(en[0]), .o_init(init[0]),
    .o_cnt0(cnt0[0]), .o_cnt1(cnt1[0]), .o_dbus_cyc(dbus[0]),
    .o_done(done[0]), .o_misalign(misal[0]), .o_cnt(cnt[0])
  );

  serv_bufreg_seq #(.ALIGN_CHK(0), .SHIFT_EN(0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start),
    .i_op(i_op), .i_size(i_size), .i_shamt(i_shamt),
    .i_lsb(i_lsb), .i_dbus_ack(i_dbus_ack),
    .o_busy(busy[1]), .o_en(en[1]), .o_init(init[1]),
    .o_cnt0(cnt0[1]), .o_cnt1(cnt1[1]), .o_dbus_cyc(dbus[1]),
    .o_done(done[1]), .o_misalign(misal[1]), .o_cnt(cnt[1])
  );

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  // Model: k = cycle number T_k since start, dk = DONE cycle
  int ac [2] = '{1, 0};
  int se [2] = '{1, 0};
  int act [2], k [2], path [2], dk [2], mis [2], msh [2];
  int mop [2], msz [2];

  function automatic void mdl_step(int m);
    bit ls, bad;
    if (!rst_n) begin
      act[m] = 0;
      return;
    end
    if (act[m] == 0) begin
      if (i_start) begin
        act[m] = 1; k[m] = 1; path[m] = 0;
        dk[m] = 0; mis[m] = 0;
        mop[m] = int'(i_op); msz[m] = int'(i_size);
        msh[m] = int'(i_shamt);
      end
      return;
    end
    if (k[m] == 33) begin
      ls  = mop[m] < 2;
      bad = (msz[m] == 1 && i_lsb[0]) ||
            (msz[m] >= 2 && i_lsb != 2'b00);
      if (ls && ac[m] != 0 && bad) begin
        dk[m] = 34; mis[m] = 1;
      end else if (ls) begin
        path[m] = 1;
      end else if (mop[m] == 2 && se[m] != 0 && msh[m] != 0) begin
        path[m] = 2; dk[m] = 34 + msh[m];
      end else begin
        dk[m] = 34;
      end
    end else if (path[m] == 1 && dk[m] == 0 && i_dbus_ack) begin
      dk[m] = k[m] + 1;
    end
    if (dk[m] != 0 && k[m] == dk[m]) act[m] = 0;
    else k[m]++;
  endfunction

  function automatic logic [12:0] mexp(int m);
    logic ini, shf, bus, dn;
    logic [4:0] c;
    if (act[m] == 0) return 13'd0;
    ini = k[m] <= 32;
    shf = path[m] == 2 && k[m] >= 34 && k[m] < dk[m];
    bus = path[m] == 1 && k[m] >= 34 && dk[m] == 0;
    dn  = k[m] == dk[m];
    c = ini ? 5'(k[m] - 1) : (shf ? 5'(k[m] - 34) : 5'd0);
    return {1'b1, ini | shf, ini, k[m] == 1, k[m] == 2,
            bus, dn, dn & (mis[m] != 0), c};
  endfunction

  function automatic logic [12:0] obs(int m);
    return {busy[m], en[m], init[m], cnt0[m], cnt1[m],
            dbus[m], done[m], misal[m], cnt[m]};
  endfunction

  // Per-cycle comparison of both instances against the model
  initial begin
    act = '{0, 0};
    forever begin
      @(posedge clk);
      mdl_step(0);
      mdl_step(1);
      #1;
      chk("cyc_a", 32'(obs(0)), 32'(mexp(0)));
      chk("cyc_b", 32'(obs(1)), 32'(mexp(1)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_op(logic [1:0] op, logic [1:0] sz,
                          logic [4:0] sh);
    i_op = op; i_size = sz; i_shamt = sh;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy != 2'b00 && n < 100) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(busy), 0);
  endtask

  task automatic run_op(logic [1:0] op, logic [1:0] sz,
                        logic [4:0] sh, logic [1:0] lsb, int dly);
    i_lsb = lsb;
    start_op(op, sz, sh);
    repeat (32 + dly) tick();
    i_dbus_ack = 1'b1;
    wait_idle();
    i_dbus_ack = 1'b0;
    tick();
  endtask

  initial begin
    int nd;
    rst_n = 1'b0; i_start = 1'b0; i_op = 2'b00; i_size = 2'b00;
    i_shamt = 5'd0; i_lsb = 2'b00; i_dbus_ack = 1'b0;
    tick();
    tick();
    chk("rst_state", 32'(obs(0)), 0);
    rst_n = 1'b1;
    tick();

    // word load, ack on first bus cycle
    i_size = 2'b10;
    start_op(2'b00, 2'b10, 5'd0);
    chk("t1_cnt0", 32'({cnt0[0], init[0], cnt[0]}), 32'h60);
    tick();
    chk("t2_cnt1", 32'({cnt0[0], cnt1[0], cnt[0]}), 32'h21);
    repeat (30) tick();
    chk("t32_init", 32'({init[0], cnt[0]}), 32'h3f);
    tick();
    chk("t33_chk", 32'({busy[0], en[0], init[0]}), 32'h4);
    i_dbus_ack = 1'b1;
    tick();
    chk("t34_bus", 32'(dbus[0]), 1);
    tick();
    i_dbus_ack = 1'b0;
    chk("t35_done", 32'({done[0], misal[0], dbus[0]}), 32'h4);
    tick();
    chk("t36_idle", 32'(busy[0]), 0);

    // store with delayed ack and a spurious ack during init
    start_op(2'b01, 2'b10, 5'd0);
    repeat (9) tick();
    i_dbus_ack = 1'b1;
    tick();
    i_dbus_ack = 1'b0;
    repeat (23) tick();
    chk("st_t34_bus", 32'(dbus[0]), 1);
    repeat (5) tick();
    chk("st_t39_bus", 32'({dbus[0], done[0]}), 32'h2);
    i_dbus_ack = 1'b1;
    tick();
    i_dbus_ack = 1'b0;
    chk("st_t40_done", 32'({dbus[0], done[0]}), 32'h1);
    tick();

    // misaligned half load; unchecked instance goes to the bus
    i_lsb = 2'b01;
    start_op(2'b00, 2'b01, 5'd0);
    repeat (33) tick();
    chk("mis_a", 32'({done[0], misal[0], dbus[0]}), 32'h6);
    chk("mis_b_bus", 32'({dbus[1], done[1]}), 32'h2);
    i_dbus_ack = 1'b1;
    tick();
    i_dbus_ack = 1'b0;
    chk("mis_b_done", 32'({done[1], misal[1]}), 32'h2);
    tick();
    i_lsb = 2'b00;

    // shift by 7, then shift by 0
    start_op(2'b10, 2'b00, 5'd7);
    repeat (33) tick();
    chk("sh_t34", 32'({en[0], init[0], cnt[0]}), 32'h40);
    chk("sh_b_done", 32'(done[1]), 1);
    repeat (6) tick();
    chk("sh_t40", 32'({en[0], done[0], cnt[0]}), 32'h46);
    tick();
    chk("sh_t41", 32'({en[0], done[0]}), 32'h1);
    tick();
    start_op(2'b10, 2'b00, 5'd0);
    repeat (33) tick();
    chk("sh0_t34", 32'(done[0]), 1);
    tick();

    // async reset in the middle of init
    start_op(2'b00, 2'b10, 5'd0);
    repeat (19) tick();
    #1 rst_n = 1'b0;
    #1;
    chk("arst_a", 32'(obs(0)), 0);
    chk("arst_b", 32'(obs(1)), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    start_op(2'b00, 2'b10, 5'd0);
    chk("ra_t1", 32'({cnt0[0], cnt[0]}), 32'h20);
    repeat (31) tick();
    chk("ra_t32", 32'({init[0], cnt[0]}), 32'h3f);
    i_dbus_ack = 1'b1;
    wait_idle();
    i_dbus_ack = 1'b0;
    tick();

    // start held high: back-to-back address-only ops
    i_op = 2'b11;
    i_start = 1'b1;
    tick();
    repeat (33) tick();
    chk("b2b_t34", 32'(done[0]), 1);
    tick();
    chk("b2b_t35", 32'(busy[0]), 0);
    tick();
    chk("b2b_t36", 32'({init[0], cnt0[0]}), 32'h3);
    nd = 0;
    repeat (69) begin
      tick();
      nd += int'(done[0]);
    end
    chk("b2b_dones", 32'(nd), 2);
    i_start = 1'b0;
    wait_idle();
    tick();

    // model-checked mix
    run_op(2'b00, 2'b00, 5'd0, 2'b11, 0);
    run_op(2'b01, 2'b10, 5'd0, 2'b10, 2);
    run_op(2'b01, 2'b01, 5'd0, 2'b10, 1);
    run_op(2'b11, 2'b00, 5'd0, 2'b00, 0);
    run_op(2'b10, 2'b00, 5'd31, 2'b00, 0);
    run_op(2'b10, 2'b00, 5'd1, 2'b00, 0);
    run_op(2'b00, 2'b01, 5'd0, 2'b11, 3);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
